// File: rtl/spike_window_monitor.sv
// rtl/spike_window_monitor.sv - windowed spike count, peak potential and minimum ISI monitor
module spike_window_monitor #(
    parameter int WINDOW_W = 8,
    parameter int CNT_W    = 6,
    parameter int U_W      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spike_in,
    input  logic [U_W-1:0]      u_in,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic                start,
    output logic                busy,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CNT_W-1:0]    spike_count,
    output logic                overflow,
    output logic [U_W-1:0]      max_u,
    output logic [CNT_W-1:0]    isi_min
);

    localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WINDOW_W-1:0] WIN_ONE = WINDOW_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WINDOW_W-1:0] win_cnt;
    logic [CNT_W-1:0]    isi_cnt;
    logic                seen_spike;
    logic                accept;
    logic [CNT_W-1:0]    isi_sample;

    assign accept = (state == IDLE) && start && (window_len != '0);

    // Interval to the previous spike, counting the current sample.
    assign isi_sample = (isi_cnt == CNT_MAX) ? CNT_MAX : isi_cnt + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (win_cnt == WIN_ONE) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status flags are flopped from the next state so they track the FSM without decode logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= (state_next != IDLE);
            result_valid <= (state_next == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt     <= '0;
            isi_cnt     <= '0;
            seen_spike  <= 1'b0;
            spike_count <= '0;
            overflow    <= 1'b0;
            max_u       <= '0;
            isi_min     <= CNT_MAX;
        end else if (accept) begin
            win_cnt     <= window_len;
            isi_cnt     <= '0;
            seen_spike  <= 1'b0;
            spike_count <= '0;
            overflow    <= 1'b0;
            max_u       <= '0;
            isi_min     <= CNT_MAX;
        end else if (state == RUN) begin
            win_cnt <= win_cnt - 1'b1;
            if (u_in > max_u) begin
                max_u <= u_in;
            end
            if (spike_in) begin
                if (spike_count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    spike_count <= spike_count + 1'b1;
                end
                if (seen_spike && (isi_sample < isi_min)) begin
                    isi_min <= isi_sample;
                end
                isi_cnt    <= '0;
                seen_spike <= 1'b1;
            end else begin
                isi_cnt <= isi_sample;
            end
        end
    end

endmodule

// File: tb/tb_spike_window_monitor.sv
// tb/tb_spike_window_monitor.sv - scoreboard bench for spike_window_monitor
module tb_spike_window_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       spike_in;
    logic [2:0] u_in;
    logic [7:0] window_len;
    logic       start;
    logic       busy;
    logic       result_valid;
    logic       result_ready;
    logic [5:0] spike_count;
    logic       overflow;
    logic [2:0] max_u;
    logic [5:0] isi_min;

    spike_window_monitor #(.WINDOW_W(8), .CNT_W(6), .U_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .spike_in(spike_in),
        .u_in(u_in),
        .window_len(window_len),
        .start(start),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .spike_count(spike_count),
        .overflow(overflow),
        .max_u(max_u),
        .isi_min(isi_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int ovf;
        int maxu;
        int isi;
        int len;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   start_cyc;
    bit   spk[0:255];
    int   uu[0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 256; i++) begin
            spk[i] = 1'b0;
            uu[i]  = 0;
        end
    endtask

    // Reference model: count spikes, track peak, take min gap between spike indices.
    task automatic push_expected(input int n);
        exp_t e;
        int   cnt = 0;
        int   last = -1;
        int   d;
        e.maxu = 0;
        e.isi  = 63;
        for (int i = 1; i <= n; i++) begin
            if (uu[i] > e.maxu) e.maxu = uu[i];
            if (spk[i]) begin
                cnt++;
                if (last >= 0) begin
                    d = i - last;
                    if (d > 63) d = 63;
                    if (d < e.isi) e.isi = d;
                end
                last = i;
            end
        end
        e.count = (cnt > 63) ? 63 : cnt;
        e.ovf   = (cnt > 63) ? 1 : 0;
        e.len   = n;
        q.push_back(e);
    endtask

    // Called #1 after an edge; drives start, then all n samples.
    task automatic do_window(input int n);
        push_expected(n);
        start      = 1'b1;
        window_len = 8'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        for (int i = 1; i <= n; i++) begin
            spike_in = spk[i];
            u_in     = 3'(uu[i]);
            @(posedge clk); #1;
        end
        spike_in = 1'b0;
        u_in     = 3'd0;
    endtask

    task automatic wait_result(input bit ack);
        int waited = 0;
        while (!result_valid && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            last_exp = q.pop_front();
            check("result_valid", int'(result_valid), 1);
            check("latency", cyc - start_cyc, last_exp.len);
            check("spike_count", int'(spike_count), last_exp.count);
            check("overflow", int'(overflow), last_exp.ovf);
            check("max_u", int'(max_u), last_exp.maxu);
            check("isi_min", int'(isi_min), last_exp.isi);
        end
        if (ack) begin
            result_ready = 1'b1;
            @(posedge clk); #1;
            result_ready = 1'b0;
            check("valid_after_ack", int'(result_valid), 0);
            check("busy_after_ack", int'(busy), 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        spike_in     = 1'b0;
        u_in         = 3'd0;
        window_len   = 8'd0;
        start        = 1'b0;
        result_ready = 1'b0;
        clear_pat();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_count", int'(spike_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_max_u", int'(max_u), 0);
        check("rst_isi", int'(isi_min), 63);

        // Basic window
        clear_pat();
        spk[2] = 1; spk[5] = 1; spk[6] = 1;
        uu[1] = 2; uu[2] = 3; uu[3] = 1; uu[4] = 5; uu[5] = 4; uu[7] = 2;
        do_window(10);
        wait_result(1'b1);

        // Saturation
        clear_pat();
        for (int i = 1; i <= 100; i++) begin
            spk[i] = 1;
            uu[i]  = int'($urandom_range(0, 6));
        end
        do_window(100);
        wait_result(1'b1);

        // Single spike
        clear_pat();
        spk[9] = 1; uu[9] = 7;
        do_window(20);
        wait_result(1'b1);

        // Wide spacing saturates the ISI
        clear_pat();
        spk[1] = 1; spk[80] = 1; spk[150] = 1; uu[40] = 6;
        do_window(160);
        wait_result(1'b1);

        // Zero-length start is ignored
        start      = 1'b1;
        window_len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("zero_len_busy", int'(busy), 0);
        end
        start = 1'b0;

        // Back-pressure with start pulses in HOLD
        clear_pat();
        spk[3] = 1; spk[7] = 1; spk[12] = 1; uu[6] = 4;
        do_window(12);
        wait_result(1'b0);
        start      = 1'b1;
        window_len = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", int'(result_valid), 1);
            check("hold_busy", int'(busy), 1);
            check("hold_count", int'(spike_count), last_exp.count);
            check("hold_isi", int'(isi_min), last_exp.isi);
            check("hold_max_u", int'(max_u), last_exp.maxu);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start        = 1'b0;
        check("bp_valid_after_ack", int'(result_valid), 0);
        check("bp_busy_after_ack", int'(busy), 0);
        check("idle_keeps_count", int'(spike_count), last_exp.count);
        clear_pat();
        spk[2] = 1; spk[4] = 1; uu[5] = 3;
        do_window(5);
        wait_result(1'b1);

        // Reset mid-run at sample 4
        clear_pat();
        start      = 1'b1;
        window_len = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            spike_in = 1'b1;
            u_in     = 3'd6;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        spike_in = 1'b0;
        u_in     = 3'd0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(result_valid), 0);
        check("midrst_count", int'(spike_count), 0);
        check("midrst_max_u", int'(max_u), 0);
        check("midrst_isi", int'(isi_min), 63);
        clear_pat();
        spk[2] = 1; spk[7] = 1; uu[3] = 1;
        do_window(8);
        wait_result(1'b1);

        if (q.size() != 0) check("scoreboard_leftover", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
